// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32 funct3
// width/sign encodings, the access FSM state type and funct3 legality helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Stores have no unsigned variants.
  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//  funct3, off      : access width/sign and byte offset within the word
//  store_data       : rs2 value to be placed on the write lanes
//  rdata            : raw memory word for load extraction
//  byteen, wdata    : store byte enables and lane-replicated store data
//  load_ext         : sign/zero-extended load result
//  misaligned       : halfword on odd address or word not on 4-byte boundary
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata[7:0];
    case (off)
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      2'd3:    rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    byteen     = 4'b0000;
    wdata      = store_data;
    load_ext   = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byteen   = 4'b0001 << off;
        wdata    = {4{store_data[7:0]}};
        load_ext = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      F3_H, F3_HU: begin
        byteen     = off[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_ext   = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
        misaligned = off[0];
      end
      F3_W: begin
        byteen     = 4'b1111;
        wdata      = store_data;
        load_ext   = rdata;
        misaligned = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine. Takes one load or store from the EX/MEM
// register, drives a multicycle word memory over a req/ack handshake and
// stalls the pipeline (busywait) until the access completes.
//  clk, reset            : clock, synchronous active-high reset
//  mem_read/mem_write    : load/store request
//  funct3, addr          : width/sign and byte address
//  store_data            : store value (rs2)
//  busywait              : combinational stall to the pipeline
//  load_data             : extended load result, held until next load
//  access_fault          : one-cycle pulse (misaligned/illegal/timeout)
//  dmem_*                : registered memory request, rdata/ack returned
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busywait,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byteen,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_inc;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [3:0]  al_byteen;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned;
  logic        req_rd, req_wr, any_req, bad, go, timeout;
  logic        busy, fault;

  // In IDLE the aligner works on the live request; while waiting it works on
  // the latched width/offset so the returning word is extracted correctly.
  assign f3_sel  = (state == IDLE) ? funct3    : f3_q;
  assign off_sel = (state == IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3     (f3_sel),
    .off        (off_sel),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .byteen     (al_byteen),
    .wdata      (al_wdata),
    .load_ext   (al_load),
    .misaligned (al_misaligned)
  );

  assign any_req = mem_read | mem_write;
  assign req_rd  = mem_read & ~mem_write;
  assign req_wr  = mem_write & ~mem_read;
  assign bad     = (mem_read & mem_write)
                 | (req_rd & ~load_f3_legal(funct3))
                 | (req_wr & ~store_f3_legal(funct3))
                 | (any_req & al_misaligned);
  assign go      = (req_rd | req_wr) & ~bad;

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign timeout = (cnt_inc == 8'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          busy      = 1'b1;
          state_nxt = req_rd ? RD_WAIT : WR_WAIT;
        end else if (any_req) begin
          fault = 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        busy = 1'b1;
        if (dmem_ack) begin
          state_nxt = DONE;
        end else if (timeout) begin
          fault     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign busywait     = busy & ~reset;
  assign access_fault = fault & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'h0;
      f3_q        <= 3'h0;
      off_q       <= 2'h0;
      load_data   <= 32'h0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      dmem_addr   <= 30'h0;
      dmem_wdata  <= 32'h0;
      dmem_byteen <= 4'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= 8'h0;
          if (go) begin
            f3_q        <= funct3;
            off_q       <= addr[1:0];
            dmem_addr   <= addr[31:2];
            dmem_read   <= req_rd;
            dmem_write  <= req_wr;
            dmem_wdata  <= req_wr ? al_wdata  : 32'h0;
            dmem_byteen <= req_wr ? al_byteen : 4'h0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          cnt <= cnt_inc;
          if (dmem_ack || timeout) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
          end
          if (state == RD_WAIT && dmem_ack)
            load_data <= al_load;
        end
        default: cnt <= 8'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busywait, access_fault;
  logic [31:0] load_data;
  logic        dmem_read, dmem_write;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .busywait(busywait), .load_data(load_data), .access_fault(access_fault),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byteen(dmem_byteen),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- memory model: ack in the Nth wait cycle (0 = never) ----
  logic [31:0] mem [0:255];
  int          ack_delay;
  int          mcnt;
  logic        force_ack;
  logic        model_ack;

  assign model_ack  = (dmem_read | dmem_write) && (ack_delay > 0) && (mcnt == ack_delay - 1);
  assign dmem_ack   = model_ack | force_ack;
  assign dmem_rdata = mem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (dmem_read | dmem_write) begin
      mcnt <= dmem_ack ? 0 : mcnt + 1;
      if (dmem_write && dmem_ack)
        for (int b = 0; b < 4; b++)
          if (dmem_byteen[b]) mem[dmem_addr[7:0]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end else begin
      mcnt <= 0;
    end
  end

  // ---------------- scoreboard -------------------------------------------
  typedef struct {
    logic [31:0] ld;
    logic        flt;
  } exp_t;
  exp_t sb[$];

  // A completed access shows as the one cycle where a request is present and
  // the stall is released (DONE, or an IDLE fault).
  initial begin
    exp_t e;
    logic fault_seen;
    fault_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fault_seen = 1'b0;
      end else begin
        if (access_fault) fault_seen = 1'b1;
        if ((mem_read | mem_write) && !busywait) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("load_data", load_data, e.ld);
            chk("fault", {31'h0, fault_seen}, {31'h0, e.flt});
          end
          fault_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver -----------------------------------------------
  int          busy_n, rq_n;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd;

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] exp_ld, input logic exp_flt);
    exp_t e;
    logic done, first;
    e.ld = exp_ld; e.flt = exp_flt;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    busy_n = 0; rq_n = 0; done = 1'b0; first = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (dmem_read | dmem_write) begin
        rq_n++;
        if (first) begin
          obs_addr = dmem_addr; obs_be = dmem_byteen; obs_wd = dmem_wdata;
          first = 1'b0;
        end
      end
      if (!busywait) done = 1'b1;
      else busy_n++;
    end
    chk("req_completes", {31'h0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
    mem[8'h40] = 32'h80AA_BBCC;
    mem[8'h80] = 32'hAAAA_BBBB;
    mem[8'h10] = 32'h7F80_FF01;
    mem[8'h11] = 32'h1122_3344;
    mem[8'h00] = 32'h0000_0000;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'h0;
    addr = 32'h0; store_data = 32'h0; ack_delay = 1; force_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busywait", {31'h0, busywait}, 32'd0);
    chk("rst_fault", {31'h0, access_fault}, 32'd0);
    chk("rst_dmem_rw", {30'h0, dmem_read, dmem_write}, 32'd0);
    chk("rst_dmem_addr", {2'b0, dmem_addr}, 32'd0);
    chk("rst_dmem_be_wd", {28'h0, dmem_byteen} | dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1;

    // LB at 0x103, ack in the 2nd wait cycle
    ack_delay = 2;
    do_req(1, 0, F3_B, 32'h103, 0, 32'hFFFF_FF80, 0);
    chk("lb_busy_cycles", busy_n, 32'd3);
    chk("lb_wait_cycles", rq_n, 32'd2);
    idle(1);

    // SH at 0x202
    ack_delay = 3;
    do_req(0, 1, F3_H, 32'h202, 32'h1234_5678, 32'hFFFF_FF80, 0);
    chk("sh_addr", {2'b0, obs_addr}, 32'h80);
    chk("sh_byteen", {28'h0, obs_be}, 32'hC);
    chk("sh_wdata", obs_wd, 32'h5678_5678);
    chk("sh_write_until_ack", rq_n, 32'd3);
    idle(1);
    ack_delay = 1;
    do_req(1, 0, F3_W, 32'h200, 0, 32'h5678_BBBB, 0);
    chk("lw_busy_cycles", busy_n, 32'd2);
    idle(1);

    // faults in IDLE: no request, no stall, load_data held
    do_req(1, 0, F3_W, 32'h102, 0, 32'h5678_BBBB, 1);
    chk("lw_mis_busy", busy_n, 32'd0);
    chk("lw_mis_noreq", rq_n, 32'd0);
    idle(1);
    @(negedge clk);
    chk("lw_mis_dmem_read", {31'h0, dmem_read}, 32'd0);
    @(posedge clk); #1;
    do_req(0, 1, F3_H, 32'h201, 32'h1, 32'h5678_BBBB, 1);
    chk("sh_mis_noreq", rq_n, 32'd0);
    idle(1);
    do_req(0, 1, F3_BU, 32'h200, 32'h1, 32'h5678_BBBB, 1);
    chk("s_illegal_noreq", rq_n, 32'd0);
    idle(1);
    do_req(1, 1, F3_B, 32'h200, 32'h1, 32'h5678_BBBB, 1);
    chk("rw_both_noreq", rq_n, 32'd0);
    idle(1);
    do_req(1, 0, F3_H, 32'h43, 0, 32'h5678_BBBB, 1);
    do_req(1, 0, 3'b011, 32'h40, 0, 32'h5678_BBBB, 1);
    idle(1);

    // load extension across offsets, word 0x7F80_FF01 at 0x40
    do_req(1, 0, F3_B,  32'h41, 0, 32'hFFFF_FFFF, 0);
    do_req(1, 0, F3_BU, 32'h41, 0, 32'h0000_00FF, 0);
    do_req(1, 0, F3_B,  32'h43, 0, 32'h0000_007F, 0);
    do_req(1, 0, F3_BU, 32'h42, 0, 32'h0000_0080, 0);
    do_req(1, 0, F3_H,  32'h42, 0, 32'h0000_7F80, 0);
    do_req(1, 0, F3_H,  32'h40, 0, 32'hFFFF_FF01, 0);
    do_req(1, 0, F3_HU, 32'h40, 0, 32'h0000_FF01, 0);
    do_req(1, 0, F3_W,  32'h40, 0, 32'h7F80_FF01, 0);
    idle(1);

    // SB lane steering then read back
    do_req(0, 1, F3_B, 32'h45, 32'h0000_00AB, 32'h7F80_FF01, 0);
    chk("sb_byteen", {28'h0, obs_be}, 32'h2);
    chk("sb_wdata", obs_wd, 32'hABAB_ABAB);
    do_req(1, 0, F3_W, 32'h44, 0, 32'h1122_AB44, 0);
    idle(1);

    // timeout: never acked
    ack_delay = 0;
    do_req(1, 0, F3_HU, 32'h0, 0, 32'h1122_AB44, 1);
    chk("to_busy_cycles", busy_n, 32'd5);
    chk("to_req_cycles", rq_n, 32'd4);
    idle(1);

    // back-to-back SW then LW
    ack_delay = 1;
    do_req(0, 1, F3_W, 32'h0, 32'hDEAD_BEEF, 32'h1122_AB44, 0);
    chk("sw_byteen", {28'h0, obs_be}, 32'hF);
    do_req(1, 0, F3_W, 32'h0, 0, 32'hDEAD_BEEF, 0);
    chk("b2b_lw_busy", busy_n, 32'd2);
    idle(1);

    // reset during RD_WAIT
    ack_delay = 0;
    mem_read = 1'b1; funct3 = F3_W; addr = 32'h0;
    repeat (3) @(negedge clk);
    chk("mid_dmem_read", {31'h0, dmem_read}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_dmem_read", {31'h0, dmem_read}, 32'd0);
    chk("rstmid_busywait", {31'h0, busywait}, 32'd0);
    chk("rstmid_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; reset = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_busy", {31'h0, busywait}, 32'd0);
    chk("stray_ack_ld", load_data, 32'd0);
    chk("stray_ack_rd", {31'h0, dmem_read}, 32'd0);
    @(posedge clk); #1 force_ack = 1'b0;
    ack_delay = 1;
    do_req(1, 0, F3_W, 32'h40, 0, 32'h7F80_FF01, 0);
    idle(2);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
